// File: rtl/disp_pkg.sv
// Shared definitions for the 7-segment display blocks.
//   NDIG      : number of digits on the display
//   ADR_W     : width of a digit address
//   AN_OFF    : anode pattern with every digit dark (anodes are active-low)
//   an_decode : digit address -> active-low one-hot anode pattern
package disp_pkg;

    localparam int NDIG  = 4;
    localparam int ADR_W = 2;

    localparam logic [NDIG-1:0] AN_OFF = 4'b1111;

    function automatic logic [NDIG-1:0] an_decode(input logic [ADR_W-1:0] adr);
        logic [NDIG-1:0] w_one;
        w_one     = NDIG'(1);
        an_decode = ~(w_one << adr);
    endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Clock-enable prescaler shared by the display blocks.
// Counts 0..CLK_DIV-1 and wraps; ce is high during the wrap cycle only.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous reset, active-high (counter returns to 0)
//   ce  : one-cycle enable pulse, once every CLK_DIV cycles
module disp_prescaler #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic ce
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Decoded straight from the counter so the reset value of the counter
    // forces ce low immediately on reset.
    assign ce = w_wrap;

endmodule

// File: rtl/disp_scan_ptr.sv
// Scan controller for the 4-digit 7-segment display.
// Steps the digit address round-robin, drives the active-low anodes, selects
// the digit nibble for the addressed position and holds the decimal-point
// pointer moved by debounced left/right button pulses.
// Optional feature, macro LEAD_ZERO_BLANK_EN: leading-zero blanking. Digit
// i>0 is dark when nibbles i..3 are all zero and i lies left of the pointer.
// Without the macro every digit is always lit.
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous reset, active-high
//   btn_l   : 1-cycle pulse, move decimal point one digit left (ptr+1)
//   btn_r   : 1-cycle pulse, move decimal point one digit right (ptr-1)
//   dat     : display value, nibble i = digit i (digit 0 rightmost)
//   adr_An  : current digit address
//   ptr     : decimal-point position
//   AN      : anode enables, active-low, one-hot-low
//   dig     : digit code of the addressed digit
//   ce_scan : 1-cycle pulse on every digit step
// No handshake: downstream stages are purely combinational on adr_An/ptr.
module disp_scan_ptr
    import disp_pkg::*;
#(
    parameter int               CLK_DIV  = 50000,
    parameter logic [ADR_W-1:0] PTR_INIT = 2'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_l,
    input  logic             btn_r,
    input  logic [15:0]      dat,
    output logic [ADR_W-1:0] adr_An,
    output logic [ADR_W-1:0] ptr,
    output logic [NDIG-1:0]  AN,
    output logic [3:0]       dig,
    output logic             ce_scan
);

    logic             w_ce;
    logic [ADR_W-1:0] w_adr_next;
    logic [ADR_W-1:0] w_ptr_next;
    logic [NDIG-1:0]  w_an_next;
    logic [3:0]       w_dig_next;

    logic [ADR_W-1:0] r_adr;
    logic [ADR_W-1:0] r_ptr;
    logic [NDIG-1:0]  r_an;
    logic [3:0]       r_dig;

    disp_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .ce  (w_ce)
    );

    // Address wraps 3 -> 0 naturally through the 2-bit adder.
    assign w_adr_next = w_ce ? (r_adr + 1'b1) : r_adr;

    // Pointer: both buttons together cancel out; independent of the scan step.
    always_comb begin
        w_ptr_next = r_ptr;
        case ({btn_l, btn_r})
            2'b10:   w_ptr_next = r_ptr + 1'b1;
            2'b01:   w_ptr_next = r_ptr - 1'b1;
            default: w_ptr_next = r_ptr;
        endcase
    end

    // AN and dig are loaded from the next address so all three registers
    // change on the same edge and always agree with each other.
    assign w_dig_next = dat[{w_adr_next, 2'b00} +: 4];

`ifdef LEAD_ZERO_BLANK_EN
    logic w_upper_zero;
    logic w_blank;

    // True when the addressed nibble and all nibbles left of it are zero.
    always_comb begin
        w_upper_zero = 1'b0;
        case (w_adr_next)
            2'd0:    w_upper_zero = (dat == 16'h0000);
            2'd1:    w_upper_zero = (dat[15:4] == 12'h000);
            2'd2:    w_upper_zero = (dat[15:8] == 8'h00);
            default: w_upper_zero = (dat[15:12] == 4'h0);
        endcase
    end

    // Compared against the next pointer so blanking tracks the ptr output
    // that is registered on the same edge.
    assign w_blank   = (w_adr_next != 2'd0) && w_upper_zero &&
                       (w_adr_next > w_ptr_next);
    assign w_an_next = w_blank ? AN_OFF : an_decode(w_adr_next);
`else
    assign w_an_next = an_decode(w_adr_next);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_adr <= '0;
            r_ptr <= PTR_INIT;
            r_an  <= AN_OFF;
            r_dig <= 4'h0;
        end else begin
            r_adr <= w_adr_next;
            r_ptr <= w_ptr_next;
            r_an  <= w_an_next;
            r_dig <= w_dig_next;
        end
    end

    assign adr_An  = r_adr;
    assign ptr     = r_ptr;
    assign AN      = r_an;
    assign dig     = r_dig;
    assign ce_scan = w_ce;

endmodule

// File: tb/tb_disp_scan_ptr.sv
// Bench for disp_scan_ptr (CLK_DIV=4, PTR_INIT=0). Inputs change and outputs
// are sampled on the falling clock edge.
module tb_disp_scan_ptr;

    localparam int CLK_DIV = 4;

`ifdef LEAD_ZERO_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        btn_l = 1'b0;
    logic        btn_r = 1'b0;
    logic [15:0] dat   = 16'h0000;
    logic [1:0]  adr_An;
    logic [1:0]  ptr;
    logic [3:0]  AN;
    logic [3:0]  dig;
    logic        ce_scan;

    int checks = 0;
    int errors = 0;

    // {adr[9:8], an[7:4], dig[3:0]} expected after each digit step
    logic [9:0] exp_q[$];
    logic [1:0] ptr_q[$];

    disp_scan_ptr #(
        .CLK_DIV  (CLK_DIV),
        .PTR_INIT (2'd0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_l   (btn_l),
        .btn_r   (btn_r),
        .dat     (dat),
        .adr_An  (adr_An),
        .ptr     (ptr),
        .AN      (AN),
        .dig     (dig),
        .ce_scan (ce_scan)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_btn(input logic l, input logic r);
        btn_l = l;
        btn_r = r;
        @(negedge clk);
        btn_l = 1'b0;
        btn_r = 1'b0;
    endtask

    // Leaves the bench at a falling edge where ce_scan is high.
    task automatic wait_ce(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 4 * CLK_DIV; n++) begin
            @(negedge clk);
            if (ce_scan === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        dat = 16'h1234;
        repeat (3) @(negedge clk);
        checks++; if (AN !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b expected %b", AN, 4'b1111); end
        checks++; if (adr_An !== 2'd0) begin errors++; $display("FAIL reset_adr: got %0d expected 0", adr_An); end
        checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", ptr); end
        checks++; if (dig !== 4'd0) begin errors++; $display("FAIL reset_dig: got %0d expected 0", dig); end
        checks++; if (ce_scan !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b expected 0", ce_scan); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (AN !== 4'b1110) begin errors++; $display("FAIL first_an: got %b expected %b", AN, 4'b1110); end
        checks++; if (dig !== 4'd4) begin errors++; $display("FAIL first_dig: got %0d expected 4", dig); end
        checks++; if (adr_An !== 2'd0) begin errors++; $display("FAIL first_adr: got %0d expected 0", adr_An); end
    endtask

    // Entered one edge after reset release (prescaler at 1).
    task automatic test_free_run();
        logic       prev_ce;
        logic       exp_ce;
        logic [1:0] last_adr;
        logic [9:0] e;
        int         pulses;
        exp_q.push_back({2'd1, 4'b1101, 4'd3});
        exp_q.push_back({2'd2, 4'b1011, 4'd2});
        exp_q.push_back({2'd3, 4'b0111, 4'd1});
        exp_q.push_back({2'd0, 4'b1110, 4'd4});
        prev_ce  = 1'b0;
        last_adr = 2'd0;
        pulses   = 0;
        for (int k = 2; k <= 17; k++) begin
            @(negedge clk);
            exp_ce = ((k % CLK_DIV) == CLK_DIV - 1);
            checks++; if (ce_scan !== exp_ce) begin errors++; $display("FAIL run_ce cyc%0d: got %b expected %b", k, ce_scan, exp_ce); end
            if (prev_ce) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL run_step cyc%0d: unexpected step, adr %0d", k, adr_An);
                end else begin
                    e = exp_q.pop_front();
                    last_adr = e[9:8];
                    checks++; if (adr_An !== e[9:8]) begin errors++; $display("FAIL run_adr cyc%0d: got %0d expected %0d", k, adr_An, e[9:8]); end
                    checks++; if (AN !== e[7:4]) begin errors++; $display("FAIL run_an cyc%0d: got %b expected %b", k, AN, e[7:4]); end
                    checks++; if (dig !== e[3:0]) begin errors++; $display("FAIL run_dig cyc%0d: got %0d expected %0d", k, dig, e[3:0]); end
                end
            end else begin
                checks++; if (adr_An !== last_adr) begin errors++; $display("FAIL run_hold cyc%0d: got %0d expected %0d", k, adr_An, last_adr); end
            end
            if (ce_scan === 1'b1) pulses++;
            prev_ce = ce_scan;
        end
        checks++; if (pulses != 4) begin errors++; $display("FAIL run_pulses: got %0d expected 4", pulses); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL run_missing_steps: got %0d left expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_ptr_move();
        logic [1:0] e;
        for (int i = 1; i <= 4; i++) ptr_q.push_back(2'(i % 4));
        ptr_q.push_back(2'd3);
        for (int i = 0; i < 4; i++) begin
            pulse_btn(1'b1, 1'b0);
            e = ptr_q.pop_front();
            checks++; if (ptr !== e) begin errors++; $display("FAIL ptr_left%0d: got %0d expected %0d", i, ptr, e); end
        end
        pulse_btn(1'b0, 1'b1);
        e = ptr_q.pop_front();
        checks++; if (ptr !== e) begin errors++; $display("FAIL ptr_right_wrap: got %0d expected %0d", ptr, e); end
    endtask

    task automatic test_both_buttons();
        bit         ok;
        logic [1:0] a;
        pulse_btn(1'b0, 1'b1);
        checks++; if (ptr !== 2'd2) begin errors++; $display("FAIL both_setup: got %0d expected 2", ptr); end
        pulse_btn(1'b1, 1'b1);
        checks++; if (ptr !== 2'd2) begin errors++; $display("FAIL both_hold: got %0d expected 2", ptr); end
        wait_ce(ok);
        checks++; if (!ok) begin errors++; $display("FAIL both_ce_timeout: got no ce_scan expected one within %0d cycles", 4 * CLK_DIV); end
        a = adr_An;
        pulse_btn(1'b1, 1'b1);
        checks++; if (ptr !== 2'd2) begin errors++; $display("FAIL both_ce_ptr: got %0d expected 2", ptr); end
        checks++; if (adr_An !== 2'(a + 2'd1)) begin errors++; $display("FAIL both_ce_adr: got %0d expected %0d", adr_An, 2'(a + 2'd1)); end
        wait_ce(ok);
        checks++; if (!ok) begin errors++; $display("FAIL left_ce_timeout: got no ce_scan expected one within %0d cycles", 4 * CLK_DIV); end
        a = adr_An;
        pulse_btn(1'b1, 1'b0);
        checks++; if (ptr !== 2'd3) begin errors++; $display("FAIL left_ce_ptr: got %0d expected 3", ptr); end
        checks++; if (adr_An !== 2'(a + 2'd1)) begin errors++; $display("FAIL left_ce_adr: got %0d expected %0d", adr_An, 2'(a + 2'd1)); end
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 1'b0;
        for (int n = 0; n < 8 * CLK_DIV; n++) begin
            @(negedge clk);
            if (adr_An === 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_timeout: got no adr 2 expected within %0d cycles", 8 * CLK_DIV); end
        checks++; if (ptr !== 2'd3) begin errors++; $display("FAIL mid_pre_ptr: got %0d expected 3", ptr); end
        #2 rst = 1'b1;
        #1;
        checks++; if (AN !== 4'b1111) begin errors++; $display("FAIL mid_an: got %b expected %b", AN, 4'b1111); end
        checks++; if (adr_An !== 2'd0) begin errors++; $display("FAIL mid_adr: got %0d expected 0", adr_An); end
        checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL mid_ptr: got %0d expected 0", ptr); end
        checks++; if (dig !== 4'd0) begin errors++; $display("FAIL mid_dig: got %0d expected 0", dig); end
        checks++; if (ce_scan !== 1'b0) begin errors++; $display("FAIL mid_ce: got %b expected 0", ce_scan); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (AN !== 4'b1110) begin errors++; $display("FAIL mid_release_an: got %b expected %b", AN, 4'b1110); end
        checks++; if (dig !== 4'd4) begin errors++; $display("FAIL mid_release_dig: got %0d expected 4", dig); end
    endtask

    // Scans every slot once over 16 cycles; slots above max_lit are dark
    // only when blanking is built in.
    task automatic scan_slots(input logic [15:0] dv, input int max_lit, input string tag);
        logic [1:0] slot;
        logic [3:0] e_an;
        logic [3:0] e_dig;
        logic [3:0] seen;
        seen = 4'b0000;
        for (int n = 0; n < 4 * CLK_DIV; n++) begin
            @(negedge clk);
            slot  = adr_An;
            seen[slot] = 1'b1;
            e_dig = dv[{slot, 2'b00} +: 4];
            if (BLANK_ON && (int'(slot) > max_lit)) e_an = 4'b1111;
            else e_an = ~(4'b0001 << slot);
            checks++; if (AN !== e_an) begin errors++; $display("FAIL %s_an slot%0d: got %b expected %b", tag, slot, AN, e_an); end
            checks++; if (dig !== e_dig) begin errors++; $display("FAIL %s_dig slot%0d: got %0d expected %0d", tag, slot, dig, e_dig); end
        end
        checks++; if (seen !== 4'b1111) begin errors++; $display("FAIL %s_slots: got %b expected 1111", tag, seen); end
    endtask

    task automatic test_blank();
        logic [1:0] e;
        dat = 16'h0045;
        @(negedge clk);
        checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL blank_ptr0: got %0d expected 0", ptr); end
        scan_slots(16'h0045, 1, "blank_p0");
        ptr_q.push_back(2'd1);
        ptr_q.push_back(2'd2);
        for (int i = 0; i < 2; i++) begin
            pulse_btn(1'b1, 1'b0);
            e = ptr_q.pop_front();
            checks++; if (ptr !== e) begin errors++; $display("FAIL blank_ptr_step%0d: got %0d expected %0d", i, ptr, e); end
        end
        scan_slots(16'h0045, 2, "blank_p2");
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_free_run();
        test_ptr_move();
        test_both_buttons();
        test_mid_reset();
        test_blank();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
